seg_capture_decoder: RTL and testbench

- Receive-side counterpart of the team's segment display driver. Samples the 8-bit segment bus (7 segments plus dp) and debounces it.
- Decodes each stable pattern back to a 5-bit value {dp, hex} and checks that successive values follow the driver's +1 (mod 32) count sequence.
- Used as an on-board/loopback monitor and as a bench checker for display logic.

---
 rtl/seg_pkg.sv | 32 +++
 rtl/seg_pattern_decode.sv | 37 +++
 rtl/seg_capture_decoder.sv | 118 +++++++++++
 tb/tb_seg_capture_decoder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the segment capture decoder.
// Glyph table matches the segment display driver's encoding.
package seg_pkg;

    localparam int DATA_W = 5;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    typedef enum logic [1:0] {
        S_BLANK,
        S_LOCKED,
        S_ERR
    } seg_state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational 7-segment pattern to hex digit decoder.
// Flags blank patterns separately from hex glyph hits.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] pat,
    output logic       hit,
    output logic [3:0] hex,
    output logic       blank
);

    always_comb begin
        hit   = 1'b1;
        hex   = 4'h0;
        blank = (pat == SEG_BLANK);
        unique case (1'b1)
            (pat == GLYPH_0): hex = 4'h0;
            (pat == GLYPH_1): hex = 4'h1;
            (pat == GLYPH_2): hex = 4'h2;
            (pat == GLYPH_3): hex = 4'h3;
            (pat == GLYPH_4): hex = 4'h4;
            (pat == GLYPH_5): hex = 4'h5;
            (pat == GLYPH_6): hex = 4'h6;
            (pat == GLYPH_7): hex = 4'h7;
            (pat == GLYPH_8): hex = 4'h8;
            (pat == GLYPH_9): hex = 4'h9;
            (pat == GLYPH_A): hex = 4'hA;
            (pat == GLYPH_B): hex = 4'hB;
            (pat == GLYPH_C): hex = 4'hC;
            (pat == GLYPH_D): hex = 4'hD;
            (pat == GLYPH_E): hex = 4'hE;
            (pat == GLYPH_F): hex = 4'hF;
            default:          hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_capture_decoder.sv
// Segment bus monitor: sync, debounce, decode, +1 sequence check.
// Define SEG_CAPTURE_ACTIVE_LOW_EN for common-anode (inverted) buses.
module seg_capture_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        seg_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              invalid,
    output logic              upd_stb,
    output logic              seq_ok,
    output logic              seq_err,
    output logic [CNT_W-1:0]  upd_cnt
);

    localparam logic [7:0] STAB_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);

    logic [7:0] seg_eff;
    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] cand;
    logic [7:0] stab_cnt;
    logic       accept;

    logic       dec_hit;
    logic [3:0] dec_hex;
    logic       dec_blank;

    logic [DATA_W-1:0] new_val;
    seg_state_t        state;

`ifdef SEG_CAPTURE_ACTIVE_LOW_EN
    assign seg_eff = ~seg_in;
`else
    assign seg_eff = seg_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= seg_eff;
            s2 <= s1;
        end
    end

    // stab_cnt parks at STABLE_CYCLES so accept fires once per candidate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand     <= '0;
            stab_cnt <= '0;
        end else if (s2 != cand) begin
            cand     <= s2;
            stab_cnt <= '0;
        end else if (stab_cnt < STAB_MAX) begin
            stab_cnt <= stab_cnt + 8'd1;
        end
    end

    assign accept = (s2 == cand) && (stab_cnt == STAB_LAST);

    seg_pattern_decode u_dec (
        .pat   (cand[6:0]),
        .hit   (dec_hit),
        .hex   (dec_hex),
        .blank (dec_blank)
    );

    assign new_val = {cand[7], dec_hex};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_BLANK;
            data_out <= '0;
            valid    <= 1'b0;
            invalid  <= 1'b0;
            upd_stb  <= 1'b0;
            seq_ok   <= 1'b0;
            seq_err  <= 1'b0;
            upd_cnt  <= '0;
        end else begin
            upd_stb <= 1'b0;
            seq_ok  <= 1'b0;
            seq_err <= 1'b0;
            if (accept) begin
                if (dec_blank) begin
                    state   <= S_BLANK;
                    valid   <= 1'b0;
                    invalid <= 1'b0;
                end else if (!dec_hit) begin
                    state   <= S_ERR;
                    valid   <= 1'b0;
                    invalid <= 1'b1;
                end else if (state != S_LOCKED || new_val != data_out) begin
                    state    <= S_LOCKED;
                    data_out <= new_val;
                    valid    <= 1'b1;
                    invalid  <= 1'b0;
                    upd_stb  <= 1'b1;
                    if (upd_cnt != '1)
                        upd_cnt <= upd_cnt + 1'b1;
                    if (state == S_LOCKED) begin
                        seq_ok  <= (new_val == data_out + 1'b1);
                        seq_err <= (new_val != data_out + 1'b1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_capture_decoder.sv
// Directed bench for seg_capture_decoder with a sample-run reference model.
// Honours SEG_CAPTURE_ACTIVE_LOW_EN by inverting driven patterns.
module tb_seg_capture_decoder;

    localparam int S     = 4;
    localparam int CW    = 5;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    seg_in = 8'h00;
    logic [4:0]    data_out;
    logic          valid;
    logic          invalid;
    logic          upd_stb;
    logic          seq_ok;
    logic          seq_err;
    logic [CW-1:0] upd_cnt;

    seg_capture_decoder #(.STABLE_CYCLES(S), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .seg_in   (seg_in),
        .data_out (data_out),
        .valid    (valid),
        .invalid  (invalid),
        .upd_stb  (upd_stb),
        .seq_ok   (seq_ok),
        .seq_err  (seq_err),
        .upd_cnt  (upd_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] gl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D,
                            8'h7D, 8'h07, 8'h7F, 8'h6F, 8'h77, 8'h7C,
                            8'h39, 8'h5E, 8'h79, 8'h71};

    // Reference model: a logical pattern is accepted once it has been
    // seen on S+1 consecutive clock samples; outputs move 2 edges later.
    logic [4:0] m_data = '0;
    logic       m_valid = 1'b0;
    logic       m_invalid = 1'b0;
    logic       m_upd = 1'b0;
    logic       m_ok = 1'b0;
    logic       m_err = 1'b0;
    int         m_cnt = 0;
    bit         m_locked = 1'b0;
    logic [7:0] run_val = '0;
    int         run_len = S + 1;
    bit         p1_v = 1'b0;
    bit         p2_v = 1'b0;
    logic [7:0] p1 = '0;
    logic [7:0] p2 = '0;

    function automatic logic [7:0] enc(input logic [7:0] p);
`ifdef SEG_CAPTURE_ACTIVE_LOW_EN
        return ~p;
`else
        return p;
`endif
    endfunction

    function automatic int lookup(input logic [6:0] p);
        for (int i = 0; i < 16; i++) begin
            logic [7:0] g;
            g = gl[i];
            if (g[6:0] == p)
                return i;
        end
        return -1;
    endfunction

    task automatic m_apply(input logic [7:0] p);
        int         h;
        logic [4:0] nv;
        h = lookup(p[6:0]);
        if (p[6:0] == 7'h00) begin
            m_locked  = 1'b0;
            m_valid   = 1'b0;
            m_invalid = 1'b0;
        end else if (h < 0) begin
            m_locked  = 1'b0;
            m_valid   = 1'b0;
            m_invalid = 1'b1;
        end else begin
            nv = {p[7], 4'(h)};
            if (!m_locked || nv != m_data) begin
                m_upd = 1'b1;
                if (m_locked) begin
                    if (int'(nv) == (int'(m_data) + 1) % 32)
                        m_ok = 1'b1;
                    else
                        m_err = 1'b1;
                end
                if (m_cnt < CMAX)
                    m_cnt = m_cnt + 1;
                m_data    = nv;
                m_locked  = 1'b1;
                m_valid   = 1'b1;
                m_invalid = 1'b0;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        logic [7:0] samp;
        bit         fire;
        if (!rst_n) begin
            m_data = '0; m_valid = 0; m_invalid = 0;
            m_upd = 0; m_ok = 0; m_err = 0; m_cnt = 0;
            m_locked = 0; run_val = '0; run_len = S + 1;
            p1_v = 0; p2_v = 0;
        end else begin
            m_upd = 0; m_ok = 0; m_err = 0;
            if (p2_v)
                m_apply(p2);
            p2_v = p1_v;
            p2   = p1;
            samp = enc(seg_in);
            fire = 1'b0;
            if (samp == run_val) begin
                if (run_len <= S) begin
                    run_len = run_len + 1;
                    fire = (run_len == S + 1);
                end
            end else begin
                run_val = samp;
                run_len = 1;
            end
            p1_v = fire;
            p1   = samp;
        end
    end

    int checks = 0;
    int errors = 0;
    int n_upd = 0;
    int n_ok = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            chk("data_out", 32'(data_out), 32'(m_data));
            chk("valid", 32'(valid), 32'(m_valid));
            chk("invalid", 32'(invalid), 32'(m_invalid));
            chk("upd_stb", 32'(upd_stb), 32'(m_upd));
            chk("seq_ok", 32'(seq_ok), 32'(m_ok));
            chk("seq_err", 32'(seq_err), 32'(m_err));
            chk("upd_cnt", 32'(upd_cnt), 32'(m_cnt));
        end
        if (upd_stb) n_upd++;
        if (seq_ok) n_ok++;
        if (seq_err) n_err++;
    endtask

    task automatic hold(input logic [7:0] p, input int n);
        seg_in = enc(p);
        repeat (n) tick();
    endtask

    initial begin
        seg_in = enc(8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        n_upd = 0;
        hold(8'h00, 20);
        chk("idle_upd", 32'(n_upd), 0);
        chk("idle_valid", 32'(valid), 0);
        chk("idle_invalid", 32'(invalid), 0);
        chk("idle_cnt", 32'(upd_cnt), 0);

        seg_in = enc(8'h3F);
        repeat (6) tick();
        chk("edge5_stb", 32'(upd_stb), 0);
        tick();
        chk("edge6_stb", 32'(upd_stb), 1);
        chk("edge6_data", 32'(data_out), 0);
        chk("edge6_valid", 32'(valid), 1);
        chk("edge6_seq", 32'({seq_ok, seq_err}), 0);
        chk("edge6_cnt", 32'(upd_cnt), 1);
        tick();
        chk("edge7_stb", 32'(upd_stb), 0);
        repeat (3) tick();

        n_ok = 0; n_err = 0;
        for (int i = 0; i < 16; i++)
            hold(gl[i], 10);
        hold(8'hBF, 10);
        chk("seq_data", 32'(data_out), 32'h10);
        chk("seq_ok_n", 32'(n_ok), 16);
        chk("seq_err_n", 32'(n_err), 0);
        chk("seq_cnt", 32'(upd_cnt), 17);

        n_err = 0;
        hold(8'h3F, 10);
        chk("wrap_err", 32'(n_err), 1);
        chk("wrap_data", 32'(data_out), 0);

        n_upd = 0;
        hold(8'h06, 2);
        hold(8'h3F, 10);
        chk("glitch_upd", 32'(n_upd), 0);
        chk("glitch_data", 32'(data_out), 0);

        n_upd = 0; n_ok = 0;
        hold(8'h06, 6);
        seg_in = enc(8'h3F);
        tick();
        chk("long_upd", 32'(n_upd), 1);
        chk("long_ok", 32'(n_ok), 1);
        chk("long_data", 32'(data_out), 1);
        repeat (9) tick();

        n_err = 0;
        hold(8'h4F, 10);
        chk("jump_data", 32'(data_out), 3);
        chk("jump_err", 32'(n_err), 1);
        hold(8'h01, 10);
        chk("ill_invalid", 32'(invalid), 1);
        chk("ill_valid", 32'(valid), 0);
        chk("ill_data", 32'(data_out), 3);
        n_upd = 0; n_ok = 0; n_err = 0;
        hold(8'h06, 10);
        chk("relock_valid", 32'(valid), 1);
        chk("relock_upd", 32'(n_upd), 1);
        chk("relock_seq", 32'(n_ok + n_err), 0);

        hold(8'h3F, 10);
        seg_in = enc(8'h06);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_data", 32'(data_out), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_cnt", 32'(upd_cnt), 0);
        chk("rst_pulse", 32'({upd_stb, seq_ok, seq_err}), 0);
        tick();
        rst_n = 1'b1;
        n_upd = 0; n_ok = 0; n_err = 0;
        repeat (10) tick();
        chk("post_rst_data", 32'(data_out), 1);
        chk("post_rst_upd", 32'(n_upd), 1);
        chk("post_rst_seq", 32'(n_ok + n_err), 0);
        chk("post_rst_cnt", 32'(upd_cnt), 1);

        for (int k = 0; k < 40; k++)
            hold((k % 2 == 0) ? 8'h3F : 8'h06, 8);
        chk("sat_cnt", 32'(upd_cnt), 32'(CMAX));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
